// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: merges the read-only fetch port and the read/write data
// port onto the single-ported RAM. A granted request is latched into hold
// registers. The hold registers drive the RAM unchanged until it completes
// or the watchdog aborts, because any change on the RAM inputs restarts its
// latency count.
module ram_port_arbiter #(
    parameter int                      N_BYTES   = 4,
    parameter int                      N_BITS    = N_BYTES * 8,
    parameter int                      ADDR_BITS = 32,
    parameter int                      MAX_WAIT  = 64,
    parameter logic [N_BITS-1:0]       ERR_DATA  = 32'hBAD0_BAD0
) (
    input  logic                 CLK,
    input  logic                 RST,
    // fetch port
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic                 i_ren,
    output logic [N_BITS-1:0]    i_rdata,
    output logic                 i_busy,
    // data port
    input  logic [ADDR_BITS-1:0] d_addr,
    input  logic                 d_ren,
    input  logic                 d_wen,
    input  logic [N_BITS-1:0]    d_wdata,
    input  logic [N_BYTES-1:0]   d_byte_en,
    output logic [N_BITS-1:0]    d_rdata,
    output logic                 d_busy,
    // RAM side
    output logic [ADDR_BITS-1:0] ram_addr,
    output logic [N_BITS-1:0]    ram_wdata,
    output logic [N_BYTES-1:0]   ram_byte_en,
    output logic                 ram_ren,
    output logic                 ram_wen,
    input  logic [N_BITS-1:0]    ram_rdata,
    input  logic                 ram_busy,
    // sticky watchdog flag
    output logic                 timeout_err
);

    localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // control registers
    logic             last_d;
    logic [CNT_W-1:0] wait_cnt;

    // hold registers: the only source of the ram_* outputs
    logic [ADDR_BITS-1:0] hold_addr;
    logic [N_BITS-1:0]    hold_wdata;
    logic [N_BYTES-1:0]   hold_byte_en;
    logic                 hold_ren;
    logic                 hold_wen;

    // decoded conditions
    logic i_req;
    logic d_req;
    logic serving;
    logic expired;
    logic done;
    logic abort;
    logic grant_i;
    logic grant_d;

    // The watchdog counter stops at its last value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_LAST) ? v : v + 1'b1;
    endfunction

    assign i_req   = i_ren;
    assign d_req   = d_ren | d_wen;
    assign serving = (state != IDLE);
    assign expired = (wait_cnt == CNT_LAST);
    // A real completion wins over the watchdog when both happen in one cycle.
    assign done    = serving & (~ram_busy | expired);
    assign abort   = serving & ram_busy & expired;

    // Both ports requesting: alternate, D first after reset (last_d = 0).
    assign grant_d = (state == IDLE) & d_req & (~i_req | ~last_d);
    assign grant_i = (state == IDLE) & i_req & (~d_req |  last_d);

    assign ram_addr    = hold_addr;
    assign ram_wdata   = hold_wdata;
    assign ram_byte_en = hold_byte_en;
    assign ram_ren     = hold_ren;
    assign ram_wen     = hold_wen;

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, busy and read data; a port without a request never stalls.
    always_comb begin
        state_nxt = state;
        i_busy    = i_req;
        d_busy    = d_req;
        i_rdata   = ram_rdata;
        d_rdata   = ram_rdata;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_nxt = SERVE_D;
                end else if (grant_i) begin
                    state_nxt = SERVE_I;
                end
            end
            SERVE_I: begin
                i_busy = ~done;
                if (abort) begin
                    i_rdata = ERR_DATA;
                end
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            SERVE_D: begin
                d_busy = ~done;
                if (abort) begin
                    d_rdata = ERR_DATA;
                end
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration history, watchdog counter and the sticky timeout flag.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_d      <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_i | grant_d) begin
                wait_cnt <= '0;
            end else if (serving) begin
                wait_cnt <= sat_inc(wait_cnt);
            end
            if (done) begin
                last_d <= (state == SERVE_D);
            end
            if (abort) begin
                timeout_err <= 1'b1;
            end
        end
    end

    // Latch the winning request on the grant edge; drop the strobes when the
    // transaction ends so the RAM sees a fresh 0->1 edge on the next grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            hold_addr    <= '0;
            hold_wdata   <= '0;
            hold_byte_en <= '0;
            hold_ren     <= 1'b0;
            hold_wen     <= 1'b0;
        end else if (grant_d) begin
            hold_addr    <= d_addr;
            hold_wdata   <= d_wdata;
            hold_byte_en <= d_byte_en;
            hold_ren     <= d_ren & ~d_wen;
            hold_wen     <= d_wen;
        end else if (grant_i) begin
            hold_addr    <= i_addr;
            hold_ren     <= 1'b1;
            hold_wen     <= 1'b0;
        end else if (done) begin
            hold_ren     <= 1'b0;
            hold_wen     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: a behavioural RAM whose latency count restarts
// whenever its inputs change, a table of single transactions, and
// hand-written sequences for arbitration, churn, watchdog and reset.
module tb_ram_port_arbiter;

    localparam int          NB  = 4;
    localparam int          NW  = 32;
    localparam int          AB  = 32;
    localparam int          MW  = 8;
    localparam logic [31:0] ERR = 32'hBAD0_BAD0;

    logic          CLK = 1'b0;
    logic          RST;
    logic [AB-1:0] i_addr;
    logic          i_ren;
    logic [NW-1:0] i_rdata;
    logic          i_busy;
    logic [AB-1:0] d_addr;
    logic          d_ren;
    logic          d_wen;
    logic [NW-1:0] d_wdata;
    logic [NB-1:0] d_byte_en;
    logic [NW-1:0] d_rdata;
    logic          d_busy;
    logic [AB-1:0] ram_addr;
    logic [NW-1:0] ram_wdata;
    logic [NB-1:0] ram_byte_en;
    logic          ram_ren;
    logic          ram_wen;
    logic [NW-1:0] ram_rdata;
    logic          ram_busy;
    logic          timeout_err;

    ram_port_arbiter #(
        .N_BYTES  (NB),
        .N_BITS   (NW),
        .ADDR_BITS(AB),
        .MAX_WAIT (MW),
        .ERR_DATA (ERR)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .i_addr     (i_addr),
        .i_ren      (i_ren),
        .i_rdata    (i_rdata),
        .i_busy     (i_busy),
        .d_addr     (d_addr),
        .d_ren      (d_ren),
        .d_wen      (d_wen),
        .d_wdata    (d_wdata),
        .d_byte_en  (d_byte_en),
        .d_rdata    (d_rdata),
        .d_busy     (d_busy),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_byte_en(ram_byte_en),
        .ram_ren    (ram_ren),
        .ram_wen    (ram_wen),
        .ram_rdata  (ram_rdata),
        .ram_busy   (ram_busy),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    // ---------------- behavioural RAM ----------------
    logic [31:0] mem [0:255];
    logic [69:0] ram_vec;
    logic [69:0] ram_prev = '0;
    int          age_q    = 0;
    int          age;
    int          lat      = 2;
    logic        force_busy = 1'b0;
    int          n_access = 0;
    logic        active;

    assign ram_vec   = {ram_addr, ram_wdata, ram_byte_en, ram_ren, ram_wen};
    assign ram_rdata = mem[ram_addr[7:0]];

    always_comb begin
        active   = ram_ren | ram_wen;
        age      = (ram_vec != ram_prev) ? 0 : age_q;
        ram_busy = force_busy | ~(active && (age >= lat));
    end

    always @(posedge CLK) begin
        ram_prev <= ram_vec;
        age_q    <= (age < 1000) ? age + 1 : age;
        if (active && !ram_busy) begin
            n_access <= n_access + 1;
            if (ram_wen) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_byte_en[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
                end
            end
        end
    end

    // ---------------- checking ----------------
    int errs   = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One transaction on one port; returns cycles until busy drops
    // (including the grant cycle) and the read data seen at that point.
    task automatic run_txn(input logic is_d, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be, output int cyc, output logic [31:0] rd);
        cyc = 0;
        rd  = 'x;
        if (is_d) begin
            d_addr = addr; d_wdata = wdata; d_byte_en = be; d_ren = ren; d_wen = wen;
        end else begin
            i_addr = addr; i_ren = 1'b1;
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge CLK);
            cyc++;
            if (is_d ? !d_busy : !i_busy) begin
                rd = is_d ? d_rdata : i_rdata;
                break;
            end
        end
        @(posedge CLK); #1;
        d_ren = 1'b0; d_wen = 1'b0; i_ren = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        ren;
        logic        wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          lat;
        int          exp_cyc;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog_guard
        #200000;
        $display("FAIL global_timeout: got hang expected finish");
        $fatal(1);
    end

    initial begin : main
        int          cyc;
        logic [31:0] rd;
        logic [7:0]  bpat;
        logic [7:0]  wpat;
        logic [11:0] rpat;
        logic [3:0]  seq;
        int          ncomp;
        int          both_low;
        int          bad;
        int          acc0;
        logic        fin;

        vecs[0] = '{1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 2, 4, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,        4'b0000, 2, 4, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1, 3, 32'h0};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0011, 0, 2, 32'h0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h20, 32'h0,        4'b0000, 3, 5, 32'h1122CCDD};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h20, 32'h0,        4'b0000, 0, 2, 32'h1122CCDD};
        vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 4'b1111, 1, 3, 32'h0};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 32'h30, 32'h0,        4'b0000, 1, 3, 32'hCAFEF00D};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h30, 32'h12345678, 4'b1000, 2, 4, 32'h0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 32'h30, 32'h0,        4'b0000, 2, 4, 32'h12FEF00D};

        RST = 1'b1;
        i_addr = '0; i_ren = 1'b0;
        d_addr = '0; d_ren = 1'b0; d_wen = 1'b0; d_wdata = '0; d_byte_en = '0;

        // reset state
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_ram_outputs", ram_vec, 70'h0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_i_busy_idle", i_busy, 1'b0);
        chk("rst_d_busy_idle", d_busy, 1'b0);
        @(posedge CLK); #1;
        RST = 1'b0;

        // table of single transactions
        for (int i = 0; i < 10; i++) begin
            lat = vecs[i].lat;
            run_txn(vecs[i].is_d, vecs[i].ren, vecs[i].wen, vecs[i].addr,
                    vecs[i].wdata, vecs[i].be, cyc, rd);
            chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
            if (vecs[i].ren && !vecs[i].wen) chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
        end

        // held write request: busy low exactly one cycle, two RAM accesses
        lat = 2; acc0 = n_access; bpat = '0; wpat = '0;
        d_addr = 32'h40; d_wdata = 32'h01020304; d_byte_en = 4'hF; d_wen = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            bpat = {bpat[6:0], d_busy};
            wpat = {wpat[6:0], ram_wen};
            @(posedge CLK); #1;
        end
        d_wen = 1'b0;
        chk("held_d_busy_pattern", bpat, 8'b1110_1110);
        chk("held_ram_wen_pattern", wpat, 8'b0111_0111);
        chk("held_access_count", n_access - acc0, 2);

        // simultaneous requests after reset: D, I, D, I
        RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
        lat = 1; rpat = '0; seq = '0; ncomp = 0; both_low = 0;
        i_addr = 32'h20; i_ren = 1'b1;
        d_addr = 32'h10; d_ren = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            rpat = {rpat[10:0], ram_ren};
            if (!d_busy && !i_busy) both_low++;
            if (!d_busy) begin
                seq = {seq[2:0], 1'b1}; ncomp++; rd = d_rdata;
            end else if (!i_busy) begin
                seq = {seq[2:0], 1'b0}; ncomp++;
                chk($sformatf("alt_i_rdata_%0d", ncomp), i_rdata, 32'h1122CCDD);
            end
            @(posedge CLK); #1;
        end
        i_ren = 1'b0; d_ren = 1'b0;
        chk("alt_grant_order", {ncomp[3:0], seq}, {4'd4, 4'b1010});
        chk("alt_ram_ren_gaps", rpat, 12'b0110_1101_1011);
        chk("alt_both_low", both_low, 0);
        chk("alt_d_rdata", rd, 32'hDEADBEEF);

        // d_addr churn during SERVE_D
        lat = 3; bad = 0; fin = 1'b0; rd = '0;
        d_addr = 32'h10; d_ren = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (ram_ren && ram_addr !== 32'h10) bad++;
            if (!d_busy) begin
                rd = d_rdata; fin = 1'b1;
                break;
            end
            @(posedge CLK); #1;
            d_addr = $urandom;
        end
        @(posedge CLK); #1;
        d_ren = 1'b0;
        chk("churn_addr_held", {fin, bad[7:0]}, {1'b1, 8'd0});
        chk("churn_rdata", rd, 32'hDEADBEEF);

        // watchdog abort with RAM stuck busy
        chk("wd_flag_before", timeout_err, 1'b0);
        force_busy = 1'b1;
        run_txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, cyc, rd);
        force_busy = 1'b0;
        chk("wd_cycles", cyc, 1 + MW);
        chk("wd_err_data", rd, ERR);
        chk("wd_flag_set", timeout_err, 1'b1);
        lat = 1;
        run_txn(1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 4'h0, cyc, rd);
        chk("wd_after_rdata", rd, 32'hDEADBEEF);
        chk("wd_flag_sticky", timeout_err, 1'b1);
        RST = 1'b1; @(posedge CLK); #1; RST = 1'b0;
        @(negedge CLK);
        chk("wd_flag_cleared", timeout_err, 1'b0);
        @(posedge CLK); #1;

        // reset in the middle of SERVE_I
        lat = 5;
        i_addr = 32'h20; i_ren = 1'b1;
        @(negedge CLK);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("mid_serve_entered", ram_ren, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b1;
        @(negedge CLK);
        chk("mid_rst_cycle_busy", i_busy, 1'b1);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_after_ram_zero", ram_vec, 70'h0);
        chk("mid_after_i_busy", i_busy, 1'b1);
        i_ren = 1'b0;
        @(posedge CLK); #1;
        lat = 1;
        run_txn(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0, cyc, rd);
        chk("resume_cycles", cyc, 3);
        chk("resume_rdata", rd, 32'h1122CCDD);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
